// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - ALU control decode and execute stage with registered outputs.
// Defining ALU_MULDIV_EN compiles in the iterative unsigned multiply/divide sequencer.
module alu_exec_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             lw_signal,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
        OP_SLL, OP_SRL, OP_MUL, OP_DIV, OP_ILL
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] sc_res;
    logic             busy_w;
    logic             accept;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             lw_q, lw_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    always_comb begin
        op = OP_ILL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
`ifdef ALU_MULDIV_EN
                    6'b110000: op = OP_MUL;
                    6'b110001: op = OP_DIV;
`endif
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        sc_res = '0;
        case (op)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  sc_res = a << b[SHW-1:0];
            OP_SRL:  sc_res = a >> b[SHW-1:0];
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e           state_q, state_d;
    logic [SHW:0]     count_q, count_d;
    // acc holds product high word / remainder; opa shifts multiplier out and quotient in.
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] it_acc, it_opa;
    logic             last_iter;
    logic             is_multi;

    assign is_multi  = (op == OP_MUL) || (op == OP_DIV);
    assign last_iter = (state_q != S_IDLE) && (count_q == (SHW+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && op == OP_MUL)      state_d = S_MUL;
                else if (start && op == OP_DIV) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (last_iter) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_w = (state_q != S_IDLE);
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, opa_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        it_acc    = acc_q;
        it_opa    = opa_q;
        if (state_q == S_MUL) begin
            it_acc = mul_sum[WIDTH:1];
            it_opa = {mul_sum[0], opa_q[WIDTH-1:1]};
        end else if (state_q == S_DIV) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!div_diff[WIDTH]) begin
                it_acc = div_diff[WIDTH-1:0];
                it_opa = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
                it_acc = div_shift[WIDTH-1:0];
                it_opa = {opa_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        count_d = count_q;
        if (state_q == S_IDLE) begin
            if (start && is_multi) begin
                acc_d   = '0;
                opa_d   = a;
                opb_d   = b;
                count_d = (SHW+1)'(WIDTH);
            end
        end else begin
            acc_d   = it_acc;
            opa_d   = it_opa;
            count_d = count_q - (SHW+1)'(1);
        end
    end
`else
    assign busy_w = 1'b0;
`endif

    assign accept = start && !busy_w;

    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        lw_d        = lw_q;
        illegal_d   = 1'b0;
        done_d      = 1'b0;
        if (accept) begin
            if (op == OP_ILL) begin
                illegal_d = 1'b1;
            end else begin
                lw_d = (alu_op == 2'b00);
`ifdef ALU_MULDIV_EN
                if (!is_multi) begin
`else
                begin
`endif
                    result_d    = sc_res;
                    result_hi_d = '0;
                    zero_d      = (sc_res == '0);
                    done_d      = 1'b1;
                end
            end
        end
`ifdef ALU_MULDIV_EN
        if (last_iter) begin
            result_d    = it_opa;
            result_hi_d = it_acc;
            zero_d      = (it_opa == '0);
            done_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            lw_q        <= 1'b0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            lw_q        <= lw_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign lw_signal = lw_q;
    assign illegal   = illegal_q;
    assign busy      = busy_w;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - self-checking bench for alu_exec_seq with a behavioural reference model.
module tb_alu_exec_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic [W-1:0] result, result_hi;
    logic         zero, lw_signal, illegal, busy, done;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] obs_lo, obs_hi;
    logic         obs_zero, obs_lw, obs_ill, obs_done;
    int           obs_cyc;

    logic [W-1:0] held_lo, held_hi;
    logic         held_zero, held_lw;

    alu_exec_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .result(result), .result_hi(result_hi), .zero(zero),
        .lw_signal(lw_signal), .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output bit ill, output bit multi,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
        logic [2*W-1:0] p;
        ill = 1'b0; multi = 1'b0; lo = '0; hi = '0; p = '0;
        case (op)
            2'b00: lo = av + bv;
            2'b01: lo = av - bv;
            2'b10: begin
                case (f)
                    6'h20: lo = av + bv;
                    6'h22: lo = av - bv;
                    6'h24: lo = av & bv;
                    6'h25: lo = av | bv;
                    6'h26: lo = av ^ bv;
                    6'h2A: lo = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                    6'h00: lo = av << bv[4:0];
                    6'h02: lo = av >> bv[4:0];
`ifdef ALU_MULDIV_EN
                    6'h30: begin
                        p = 64'(av) * 64'(bv);
                        lo = p[W-1:0]; hi = p[2*W-1:W]; multi = 1'b1;
                    end
                    6'h31: begin
                        multi = 1'b1;
                        if (bv == 0) begin lo = '1; hi = av; end
                        else begin lo = av / bv; hi = av % bv; end
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        alu_op = op; funct = f; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_cyc = 1;
        while (!done && !illegal && obs_cyc < 200) begin
            @(posedge clk); #1;
            obs_cyc++;
        end
        obs_lo = result; obs_hi = result_hi; obs_zero = zero;
        obs_lw = lw_signal; obs_ill = illegal; obs_done = done;
    endtask

    task automatic test_reset();
        int seen;
        checks++;
        if ({result, result_hi, zero, lw_signal, illegal, busy, done} !== '0) begin
            failures++; $display("FAIL reset_initial: outputs=%h expected all zero",
                                 {result, result_hi, zero, lw_signal, illegal, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(2'b00, 6'h00, 32'd5, 32'd7);
`ifdef ALU_MULDIV_EN
        @(negedge clk);
        alu_op = 2'b10; funct = 6'h30; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
`else
        @(posedge clk);
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({result, result_hi, zero, lw_signal, illegal, busy, done} !== '0) begin
            failures++; $display("FAIL reset_async: outputs=%h expected all zero",
                                 {result, result_hi, zero, lw_signal, illegal, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL reset_discard: done/busy cycles=%0d expected 0", seen);
        end
        do_op(2'b00, 6'h00, 32'd5, 32'd7);
        checks++;
        if (obs_lo !== 32'd12 || obs_cyc != 1 || !obs_done) begin
            failures++; $display("FAIL reset_first_add: result=%0d cycles=%0d expected 12 in 1", obs_lo, obs_cyc);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] av, bv, lo;
        logic         lw;
    } vec_t;

    task automatic test_single_cycle();
        vec_t v[6] = '{
            '{2'b00, 6'h00, 32'd5,          32'd7,      32'd12,     1'b1},
            '{2'b01, 6'h00, 32'd9,          32'd9,      32'd0,      1'b0},
            '{2'b10, 6'h00, 32'd1,          32'd4,      32'd16,     1'b0},
            '{2'b10, 6'h02, 32'h8000_0000,  32'd31,     32'd1,      1'b0},
            '{2'b10, 6'h2A, 32'hFFFF_FFFF,  32'd1,      32'd1,      1'b0},
            '{2'b10, 6'h26, 32'h0000_F0F0,  32'h0000_FFFF, 32'h0000_0F0F, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].op, v[i].f, v[i].av, v[i].bv);
            checks++;
            if (obs_lo !== v[i].lo) begin
                failures++; $display("FAIL single[%0d] result: got %h expected %h", i, obs_lo, v[i].lo);
            end
            checks++;
            if (obs_hi !== '0) begin
                failures++; $display("FAIL single[%0d] result_hi: got %h expected 0", i, obs_hi);
            end
            checks++;
            if (obs_zero !== (v[i].lo == 0)) begin
                failures++; $display("FAIL single[%0d] zero: got %b expected %b", i, obs_zero, v[i].lo == 0);
            end
            checks++;
            if (obs_lw !== v[i].lw) begin
                failures++; $display("FAIL single[%0d] lw_signal: got %b expected %b", i, obs_lw, v[i].lw);
            end
            checks++;
            if (!obs_done || obs_cyc != 1) begin
                failures++; $display("FAIL single[%0d] latency: done=%b cycles=%0d expected 1", i, obs_done, obs_cyc);
            end
        end
    endtask

    task automatic test_illegal();
        do_op(2'b00, 6'h00, 32'd3, 32'd4);
        do_op(2'b10, 6'h3F, 32'd100, 32'd200);
        checks++;
        if (obs_ill !== 1'b1 || obs_done !== 1'b0 || obs_cyc != 1) begin
            failures++; $display("FAIL illegal_funct: illegal=%b done=%b cycles=%0d expected 1/0/1", obs_ill, obs_done, obs_cyc);
        end
        checks++;
        if (obs_lo !== 32'd7 || obs_lw !== 1'b1 || obs_zero !== 1'b0) begin
            failures++; $display("FAIL illegal_hold: result=%0d lw=%b zero=%b expected 7/1/0", obs_lo, obs_lw, obs_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL illegal_pulse: illegal=%b done=%b expected 0/0", illegal, done);
        end
        do_op(2'b11, 6'h20, 32'd1, 32'd1);
        checks++;
        if (obs_ill !== 1'b1 || obs_done !== 1'b0 || obs_lo !== 32'd7) begin
            failures++; $display("FAIL illegal_op11: illegal=%b done=%b result=%0d expected 1/0/7", obs_ill, obs_done, obs_lo);
        end
    endtask

    task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
        int cyc;
        int busy_bad;
        @(negedge clk);
        alu_op = 2'b10; funct = 6'h30; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1; busy_bad = 0;
        while (!done && cyc < 200) begin
            if (!busy) busy_bad++;
            // A start pulse during busy must be ignored.
            start = (cyc == 5);
            alu_op = 2'b00; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (result !== 32'hFFFF_FFFE || result_hi !== 32'd1) begin
            failures++; $display("FAIL mult_value: hi=%h lo=%h expected 00000001 fffffffe", result_hi, result);
        end
        checks++;
        if (cyc != W + 1 || busy_bad != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL mult_latency: cycles=%0d busy_gaps=%0d expected %0d/0", cyc, busy_bad, W + 1);
        end
        do_op(2'b10, 6'h31, 32'd100, 32'd7);
        checks++;
        if (obs_lo !== 32'd14 || obs_hi !== 32'd2 || obs_cyc != W + 1) begin
            failures++; $display("FAIL div_100_7: q=%0d r=%0d cycles=%0d expected 14/2/%0d", obs_lo, obs_hi, obs_cyc, W + 1);
        end
        do_op(2'b10, 6'h31, 32'd100, 32'd0);
        checks++;
        if (obs_lo !== 32'hFFFF_FFFF || obs_hi !== 32'd100 || obs_cyc != W + 1) begin
            failures++; $display("FAIL div_by_zero: q=%h r=%0d cycles=%0d expected ffffffff/100/%0d", obs_lo, obs_hi, obs_cyc, W + 1);
        end
        alu_op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'd12 || result_hi !== 32'd0) begin
            failures++; $display("FAIL b2b_after_div: done=%b result=%0d hi=%0d expected 1/12/0", done, result, result_hi);
        end
`else
        do_op(2'b10, 6'h30, 32'd3, 32'd5);
        checks++;
        if (obs_ill !== 1'b1 || obs_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mult_disabled: illegal=%b done=%b busy=%b expected 1/0/0", obs_ill, obs_done, busy);
        end
        do_op(2'b10, 6'h31, 32'd3, 32'd5);
        checks++;
        if (obs_ill !== 1'b1 || obs_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL div_disabled: illegal=%b done=%b busy=%b expected 1/0/0", obs_ill, obs_done, busy);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av, bv, e;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            av = $urandom; bv = $urandom;
            alu_op = (k % 2 == 0) ? 2'b00 : 2'b01;
            a = av; b = bv; start = 1'b1;
            e = (k % 2 == 0) ? av + bv : av - bv;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || result !== e) begin
                failures++; $display("FAIL b2b[%0d]: done=%b result=%h expected 1/%h", k, done, result, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0]   fl[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h30, 6'h31};
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] av, bv, elo, ehi;
        bit           eill, emulti;
        int           k, ecyc;
        do_op(2'b00, 6'h00, 32'd0, 32'd0);
        held_lo = '0; held_hi = '0; held_zero = 1'b1; held_lw = 1'b1;
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 7);
            op = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 7) ? 2'b11 : 2'b10;
            k  = $urandom_range(0, 10);
            f  = (k == 10) ? 6'($urandom) : fl[k];
            av = $urandom;
            bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            model(op, f, av, bv, eill, emulti, elo, ehi);
            if (!eill) begin
                held_lo = elo; held_hi = ehi; held_zero = (elo == 0); held_lw = (op == 2'b00);
            end
            ecyc = emulti ? W + 1 : 1;
            do_op(op, f, av, bv);
            checks++;
            if (obs_ill !== eill || obs_done !== !eill || obs_cyc != ecyc) begin
                failures++; $display("FAIL rand[%0d] handshake op=%b f=%h: ill=%b done=%b cyc=%0d expected %b/%b/%0d",
                                     i, op, f, obs_ill, obs_done, obs_cyc, eill, !eill, ecyc);
            end
            checks++;
            if (obs_lo !== held_lo || obs_hi !== held_hi || obs_zero !== held_zero || obs_lw !== held_lw) begin
                failures++; $display("FAIL rand[%0d] data op=%b f=%h a=%h b=%h: lo=%h hi=%h z=%b lw=%b expected %h/%h/%b/%b",
                                     i, op, f, av, bv, obs_lo, obs_hi, obs_zero, obs_lw,
                                     held_lo, held_hi, held_zero, held_lw);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_cycle();
        test_illegal();
        test_muldiv();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Parametrised ALU control and execute stage for the MIPS datapath. It decodes the 2-bit ALU opcode from main control together with the 6-bit funct field, executes single-cycle operations with registered output, and runs unsigned multiply and divide as an iterative WIDTH-cycle sequencer behind a start/busy/done handshake. It sits between the register file read stage and the writeback mux, and replaces the purely combinational ALU control decode.

## Interface
- WIDTH, 32, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; accepted only when busy=0.
- alu_op  in  2  00 add (lw/sw/addi), 01 sub (branch), 10 R-type (use funct), 11 illegal.
- funct  in  6  R-type function code.
- a, b  in  WIDTH  operands; shifts use b[SHW-1:0] as the amount, a as the value.
- result  out  WIDTH  low result / quotient.
- result_hi  out  WIDTH  mult high word / div remainder; 0 for single-cycle ops.
- zero  out  1  result == 0, registered alongside result.
- lw_signal  out  1  registered copy of (alu_op == 00) at accept.
- illegal  out  1  one-cycle pulse: undecodable op accepted.
- busy  out  1  multicycle operation in progress.
- done  out  1  one-cycle pulse: result/result_hi/zero valid.

## Operation
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt (signed, result 1/0), 000000 sll, 000010 srl (logical), 110000 mult, 110001 div. Any other funct, or alu_op=11: illegal.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start + single-cycle op: register result, result_hi=0, zero, lw_signal; pulse done; stay IDLE.
  - IDLE + start + illegal: pulse illegal; result, result_hi, zero, lw_signal hold; no done.
  - IDLE + start + mult: latch operands, clear accumulator, count=WIDTH, go MUL. Shift-add, one multiplier bit per cycle, unsigned, 2·WIDTH product {result_hi, result}.
  - IDLE + start + div: go DIV. Restoring division, one quotient bit per cycle, unsigned.
  - MUL/DIV: count decrements per cycle; on the final iteration write outputs, pulse done, return IDLE.
- Divide by zero: still WIDTH iterations; result = all ones, result_hi = a.
- start while busy=1: ignored; operands and in-flight operation unaffected.
- result and result_hi change only on the done edge; they hold between operations.

## Timing
- Reset (async assert, any state, including mid-MUL/DIV): FSM to IDLE, count=0; result, result_hi, zero, lw_signal, illegal, busy, done all 0. The in-flight operation is discarded with no done.
- Single-cycle latency: start sampled at edge E0 gives done=1 and valid outputs in the cycle after E0.
- Multicycle latency: start sampled at E0 sets busy=1 after E0. Iterations run at E1..E_WIDTH. After E_WIDTH: done=1, busy=0, outputs valid. Total WIDTH+1 cycles start-to-done (33 for WIDTH=32).
- A new start is accepted in the same cycle done is high (back-to-back), because busy is already 0.
- illegal and done are never high together.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIV states, counter and iterative datapath are compiled in, as described above.
- ALU_MULDIV_EN undefined: no sequencer. funct 110000/110001 decode as illegal, busy is tied 0, and every legal op completes in one cycle.

## Test plan
- Reset: hold rst_n=0 mid-MUL, release -> all outputs 0, no done; next add a=5, b=7 -> result 12, done after 1 cycle.
- alu_op=00, a=5, b=7 -> result 12, lw_signal 1, zero 0. alu_op=01, a=9, b=9 -> result 0, zero 1, lw_signal 0.
- R-type sll a=1, b=4 -> 16; srl a=0x80000000, b=31 -> 1; slt a=0xFFFFFFFF, b=1 -> 1; xor 0xF0F0, 0xFFFF -> 0x0F0F.
- mult a=0xFFFFFFFF, b=2 -> result_hi 0x1, result 0xFFFFFFFE; done exactly 33 cycles after start. A start pulse during busy is ignored.
- div 100/7 -> result 14, result_hi 2; div 100/0 -> result 0xFFFFFFFF, result_hi 100, both after 33 cycles; a back-to-back add is accepted in the done cycle.
- funct 111111 with alu_op=10 -> illegal pulses 1 cycle, no done, result holds its previous value. With ALU_MULDIV_EN undefined, mult -> illegal, busy stays 0.
